// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types and defaults for the bit-serial equality checker.
//   state_t   : controller states (IDLE, SHIFT, DONE), 2-bit encoding
//   N_DEFAULT : default operand width in bits
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_cmp_pkg

// File: rtl/bit_match.sv
// -----------------------------------------------------------------------------
// bit_match
// Per-bit XNOR stage: m is high when the two operand bits agree.
//   a, b : operand bits
//   m    : match flag, ~(a ^ b)
// -----------------------------------------------------------------------------
module bit_match (
  input  logic a,
  input  logic b,
  output logic m
);

  assign m = ~(a ^ b);

endmodule : bit_match

// File: rtl/serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// serial_eq_cmp
// Bit-serial equality checker. Two N-bit operands arrive LSB first, one bit
// pair per clock, starting in the cycle start is accepted. After N bits the
// block pulses done and presents word equality, the mismatch count and the
// index of the lowest differing bit. Results hold until the next start.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   start        : begin a comparison (bit 0 sampled in the same cycle)
//   a_bit, b_bit : serial operand bits
//   busy         : comparison in progress (state != IDLE)
//   done         : one-cycle pulse, results valid from this cycle onward
//   eq           : all N bit pairs matched
//   mismatch_cnt : number of differing bit positions (0..N)
//   first_diff   : index of lowest differing bit, 0 when none differ
//   diff_found   : at least one mismatch seen
// -----------------------------------------------------------------------------
module serial_eq_cmp
  import serial_cmp_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int CW = $clog2(N + 1),
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          a_bit,
  input  logic          b_bit,
  output logic          busy,
  output logic          done,
  output logic          eq,
  output logic [CW-1:0] mismatch_cnt,
  output logic [IW-1:0] first_diff,
  output logic          diff_found
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Registered state
  state_t          state;
  logic [IW-1:0]   idx;
  logic            eq_acc;

  // Next-state values
  state_t          state_n;
  logic [IW-1:0]   idx_n;
  logic            eq_acc_n;
  logic            eq_n;
  logic            done_n;
  logic            busy_n;
  logic [CW-1:0]   cnt_n;
  logic [IW-1:0]   first_n;
  logic            found_n;

  logic            m;

  bit_match u_bit_match (
    .a (a_bit),
    .b (b_bit),
    .m (m)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_n  = state;
    idx_n    = idx;
    eq_acc_n = eq_acc;
    eq_n     = eq;
    cnt_n    = mismatch_cnt;
    first_n  = first_diff;
    found_n  = diff_found;

    unique case (state)
      IDLE: begin
        if (start) begin
          eq_acc_n = m;
          cnt_n    = CW'(~m);
          found_n  = ~m;
          first_n  = '0;
          idx_n    = IW'(1);
          state_n  = SHIFT;
        end
      end

      SHIFT: begin
        eq_acc_n = eq_acc & m;
        cnt_n    = mismatch_cnt + CW'(~m);
        // Only the lowest differing index is kept; later mismatches just count.
        if (!m && !diff_found) begin
          first_n = idx;
          found_n = 1'b1;
        end
        if (idx == LAST_IDX) begin
          // eq is latched as the final bit is folded in so it is already
          // valid in the cycle done is high.
          eq_n    = eq_acc & m;
          idx_n   = '0;
          state_n = DONE;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      eq_acc       <= 1'b0;
      eq           <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      mismatch_cnt <= '0;
      first_diff   <= '0;
      diff_found   <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      eq_acc       <= eq_acc_n;
      eq           <= eq_n;
      done         <= done_n;
      busy         <= busy_n;
      mismatch_cnt <= cnt_n;
      first_diff   <= first_n;
      diff_found   <= found_n;
    end
  end

endmodule : serial_eq_cmp

// File: tb/tb_serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// tb_serial_eq_cmp
// Self-checking bench for serial_eq_cmp with N=8. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_eq_cmp;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          pulse_mid;  // extra start pulse while SHIFT
    logic          eq;
    logic [CW-1:0] cnt;
    logic [IW-1:0] first;
    logic          found;
  } vec_t;

  typedef struct {
    logic          eq;
    logic [CW-1:0] cnt;
    logic [IW-1:0] first;
    logic          found;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          eq;
  logic [CW-1:0] mismatch_cnt;
  logic [IW-1:0] first_diff;
  logic          diff_found;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp;
  bit   have_last = 1'b0;

  always #5 clk = ~clk;

  serial_eq_cmp #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a_bit        (a_bit),
    .b_bit        (b_bit),
    .busy         (busy),
    .done         (done),
    .eq           (eq),
    .mismatch_cnt (mismatch_cnt),
    .first_diff   (first_diff),
    .diff_found   (diff_found)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, ".eq"},         32'(eq),           32'(e.eq));
    check({tag, ".cnt"},        32'(mismatch_cnt), 32'(e.cnt));
    check({tag, ".first_diff"}, 32'(first_diff),   32'(e.first));
    check({tag, ".diff_found"}, 32'(diff_found),   32'(e.found));
  endtask

  task automatic check_all_zero(input string tag);
    exp_t z;
    z = '{eq: 1'b0, cnt: '0, first: '0, found: 1'b0};
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check_results(tag, z);
  endtask

  // Reference model for randomly drawn operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t         e;
    logic [N-1:0] x;
    x       = a ^ b;
    e.eq    = (a == b);
    e.cnt   = '0;
    e.first = '0;
    e.found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        e.cnt = e.cnt + CW'(1);
        if (!e.found) begin
          e.first = IW'(i);
          e.found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Streams one comparison. Entry point: just after a falling edge with the
  // DUT idle. Exit: at the falling edge where done is high (or the bound ran
  // out), inputs returned to idle values.
  task automatic run_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic pulse_mid, input exp_t e);
    exp_t got;
    int   lat;
    bit   early;
    @(negedge clk);
    // Previous results must still be visible until this start is accepted.
    if (have_last) check_results({tag, ".held"}, last_exp);
    sb.push_back(e);
    start = 1'b1;
    a_bit = a[0];
    b_bit = b[0];
    early = 1'b0;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      if (done) early = 1'b1;
      start = pulse_mid && (i == 3);
      a_bit = a[i];
      b_bit = b[i];
    end
    lat = N - 1;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      a_bit = 1'b0;
      b_bit = 1'b0;
    end while (!done && lat < N + 6);
    check({tag, ".early_done"}, 32'(early), 32'd0);
    check({tag, ".latency"},    32'(lat),   32'(N));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    if (done && sb.size() > 0) begin
      got = sb.pop_front();
      check_results(tag, got);
      last_exp  = got;
      have_last = 1'b1;
    end else begin
      check({tag, ".done_seen"}, 32'(done), 32'd1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    exp_t e;
    logic [N-1:0] ra, rb;
    int   spurious;

    vecs[0] = '{a: 8'hA5, b: 8'hA5, pulse_mid: 1'b0, eq: 1'b1, cnt: 4'd0, first: 3'd0, found: 1'b0};
    vecs[1] = '{a: 8'hA5, b: 8'h24, pulse_mid: 1'b0, eq: 1'b0, cnt: 4'd2, first: 3'd0, found: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'hF0, pulse_mid: 1'b0, eq: 1'b0, cnt: 4'd4, first: 3'd4, found: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'hFF, pulse_mid: 1'b1, eq: 1'b0, cnt: 4'd8, first: 3'd0, found: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h00, pulse_mid: 1'b0, eq: 1'b0, cnt: 4'd1, first: 3'd7, found: 1'b1};
    vecs[5] = '{a: 8'h0F, b: 8'h0F, pulse_mid: 1'b0, eq: 1'b1, cnt: 4'd0, first: 3'd0, found: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;

    // Reset for two cycles, then idle three cycles.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("idle");
    end

    // Table-driven comparisons, back to back (each start in the cycle
    // right after the previous done).
    for (int i = 0; i < 6; i++) begin
      e = '{eq: vecs[i].eq, cnt: vecs[i].cnt, first: vecs[i].first, found: vecs[i].found};
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].pulse_mid, e);
    end

    // A few random operands checked against the model.
    for (int i = 0; i < 4; i++) begin
      ra = N'($urandom);
      rb = (i == 0) ? ra : N'($urandom);
      run_cmp($sformatf("rnd%0d", i), ra, rb, 1'b0, model(ra, rb));
    end

    // Reset in the middle of a comparison: no done, outputs cleared.
    @(negedge clk);
    start = 1'b1;
    a_bit = 1'b0;
    b_bit = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      a_bit = 1'b1;
      b_bit = 1'b0;
    end
    check("mid.busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_reset");
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    check("mid_reset.no_done", 32'(spurious), 32'd0);

    // Reset wins over start in the same cycle.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_vs_start.busy", 32'(busy), 32'd0);
    have_last = 1'b0;

    // Machine still works afterwards.
    run_cmp("post_reset", 8'h3C, 8'h34, 1'b0, model(8'h3C, 8'h34));
    @(negedge clk);
    check("post_reset.idle_busy", 32'(busy), 32'd0);
    check("post_reset.done_pulse", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_eq_cmp
